axil2iob: RTL

AXIL2IOB -- requirements
Module: axil2iob

---
 rtl/axil2iob_pkg.sv | 17 +
 rtl/iob_reg_e.sv | 27 ++
 rtl/axil2iob.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axil2iob_pkg.sv
// rtl/axil2iob_pkg.sv - shared types and constants for the AXI-Lite to IOb bridge
package axil2iob_pkg;

    localparam int PROT_W = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_RESP = 3'd5
    } state_t;

endpackage

// File: rtl/iob_reg_e.sv
// rtl/iob_reg_e.sv - generic register with enable and synchronous active-high reset
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, clears q to zero
//   en   load enable
//   d    next value loaded when en is 1
//   q    registered value
module iob_reg_e #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/axil2iob.sv
// rtl/axil2iob.sv - AXI-Lite slave to IOb master bridge, one outstanding transaction
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   axil_aw*/w*/b*          AXI-Lite write address, write data and write response
//   axil_ar*/r*             AXI-Lite read address and read data
//   iob_*                   IOb master request (avalid/addr/wdata/wstrb/ready) and
//                           read return (rvalid/rdata)
// Every output is decoded from registered state only.
module axil2iob
    import axil2iob_pkg::*;
#(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32,
    parameter int ADDR_W      = AXIL_ADDR_W,
    parameter int DATA_W      = AXIL_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     axil_awvalid_i,
    output logic                     axil_awready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
    input  logic [PROT_W-1:0]        axil_awprot_i,

    input  logic                     axil_wvalid_i,
    output logic                     axil_wready_o,
    input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
    input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,

    output logic                     axil_bvalid_o,
    input  logic                     axil_bready_i,
    output logic [1:0]               axil_bresp_o,

    input  logic                     axil_arvalid_i,
    output logic                     axil_arready_o,
    input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
    input  logic [PROT_W-1:0]        axil_arprot_i,

    output logic                     axil_rvalid_o,
    input  logic                     axil_rready_i,
    output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
    output logic [1:0]               axil_rresp_o,

    output logic                     iob_avalid_o,
    output logic [ADDR_W-1:0]        iob_addr_o,
    output logic [DATA_W-1:0]        iob_wdata_o,
    output logic [DATA_W/8-1:0]      iob_wstrb_o,
    input  logic                     iob_ready_i,
    input  logic                     iob_rvalid_i,
    input  logic [DATA_W-1:0]        iob_rdata_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int AW_W   = ADDR_W + 1;
    localparam int W_W    = 1 + DATA_W + STRB_W;

    // Each holding register stores {full, payload}. A load happens either on
    // accepting a new beat (only possible while empty) or on clearing the full
    // flag (only possible while full), so the two never collide.
    logic              aw_take, aw_clr, aw_full;
    logic [ADDR_W-1:0] aw_addr;
    logic [AW_W-1:0]   aw_d, aw_q;

    logic              w_take, w_clr, w_full;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [W_W-1:0]    w_d, w_q;

    logic              ar_take, ar_clr, ar_full;
    logic [ADDR_W-1:0] ar_addr;
    logic [AW_W-1:0]   ar_d, ar_q;

    assign aw_take = axil_awvalid_i & ~aw_full;
    assign aw_d    = aw_take ? {1'b1, axil_awaddr_i[ADDR_W-1:0]} : {1'b0, aw_addr};
    assign aw_full = aw_q[AW_W-1];
    assign aw_addr = aw_q[ADDR_W-1:0];

    assign w_take  = axil_wvalid_i & ~w_full;
    assign w_d     = w_take ? {1'b1, axil_wdata_i, axil_wstrb_i} : {1'b0, w_data, w_strb};
    assign w_full  = w_q[W_W-1];
    assign w_data  = w_q[STRB_W +: DATA_W];
    assign w_strb  = w_q[STRB_W-1:0];

    assign ar_take = axil_arvalid_i & ~ar_full;
    assign ar_d    = ar_take ? {1'b1, axil_araddr_i[ADDR_W-1:0]} : {1'b0, ar_addr};
    assign ar_full = ar_q[AW_W-1];
    assign ar_addr = ar_q[ADDR_W-1:0];

    iob_reg_e #(.DATA_W(AW_W)) aw_reg (
        .clk(clk_i), .rst(rst_i), .en(aw_take | aw_clr), .d(aw_d), .q(aw_q)
    );

    iob_reg_e #(.DATA_W(W_W)) w_reg (
        .clk(clk_i), .rst(rst_i), .en(w_take | w_clr), .d(w_d), .q(w_q)
    );

    iob_reg_e #(.DATA_W(AW_W)) ar_reg (
        .clk(clk_i), .rst(rst_i), .en(ar_take | ar_clr), .d(ar_d), .q(ar_q)
    );

    assign axil_awready_o = ~aw_full;
    assign axil_wready_o  = ~w_full;
    assign axil_arready_o = ~ar_full;

    logic wr_pend, rd_pend;
    assign wr_pend = aw_full & w_full;
    assign rd_pend = ar_full;

    state_t            state, state_next;
    logic              rr, rr_next;
    logic              rdata_load;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            rr    <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            if (rdata_load) begin
                rdata <= iob_rdata_i;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rr_next      = rr;
        aw_clr       = 1'b0;
        w_clr        = 1'b0;
        ar_clr       = 1'b0;
        rdata_load   = 1'b0;
        iob_avalid_o = 1'b0;
        iob_addr_o   = '0;
        iob_wdata_o  = '0;
        iob_wstrb_o  = '0;
        case (state)
            IDLE: begin
                // rr == 0 favours the write when both are pending.
                if (wr_pend && (!rd_pend || !rr)) begin
                    rr_next = ~rr;
                    // An all-zero strobe would look like a read on IOb, so
                    // the write is acknowledged without touching the bus.
                    if (w_strb == '0) begin
                        aw_clr     = 1'b1;
                        w_clr      = 1'b1;
                        state_next = WR_RESP;
                    end else begin
                        state_next = WR_REQ;
                    end
                end else if (rd_pend) begin
                    rr_next    = ~rr;
                    state_next = RD_REQ;
                end
            end
            WR_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = aw_addr;
                iob_wdata_o  = w_data;
                iob_wstrb_o  = w_strb;
                if (iob_ready_i) begin
                    aw_clr     = 1'b1;
                    w_clr      = 1'b1;
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axil_bready_i) begin
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                iob_avalid_o = 1'b1;
                iob_addr_o   = ar_addr;
                if (iob_ready_i) begin
                    ar_clr     = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    rdata_load = 1'b1;
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axil_rready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign axil_bvalid_o = (state == WR_RESP);
    assign axil_bresp_o  = RESP_OKAY;
    assign axil_rvalid_o = (state == RD_RESP);
    assign axil_rresp_o  = RESP_OKAY;
    assign axil_rdata_o  = rdata;

    // Protection bits carry no meaning for IOb; address bits above ADDR_W are dropped.
    logic unused_ok;
    assign unused_ok = ^{axil_awprot_i, axil_arprot_i, axil_awaddr_i, axil_araddr_i};

endmodule
